ac_table_writer: RTL
====================

Name: ac_table_writer

Overview:
- Loader for the Aho-Corasick goto/failure tables. It is the write side of the same four-RAM interface that the table reader consumes.
- Accepts table entries from a host stream over a valid/ready handshake. Each entry is {current state, character, next state, failure state}.
- Clears all table rows, then writes the entries sequentially into the tables.
- Sits between the host/config path and the table RAMs. Its write port drives the RAMs that the reader later searches.

Parameters:
- DEPTH, 32, number of table rows
- AW, 5, row address width (log2 DEPTH)
- SW, 8, state field width
- CW, 4, character field width

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse: begin clear+load
- IN_VALID  in  1  entry beat valid
- IN_READY  out  1  writer can accept a beat
- IN_CUR  in  SW  current-state field
- IN_CHARA  in  CW  character field
- IN_NEXT  in  SW  goto next-state field
- IN_FAIL  in  SW  failure-state field
- IN_LAST  in  1  marks final entry of table
- WE  out  1  table write enable (all four RAMs)
- WADDR  out  AW  table row address
- W_CUR  out  SW  write data, current-state RAM
- W_CHARA  out  CW  write data, character RAM
- W_NEXT  out  SW  write data, next-state RAM
- W_FAIL  out  SW  write data, failure RAM
- BUSY  out  1  high in CLEAR or LOAD
- DONE  out  1  table valid, reader may be enabled
- COUNT  out  AW+1  entries written in current load
- ERR_FULL  out  1  DEPTH entries taken without IN_LAST

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: IN_READY, WE, WADDR, W_*, BUSY, DONE, COUNT, ERR_FULL.
  - Table contents are undefined after reset.
- FSM: IDLE -> CLEAR -> LOAD -> DONE. DONE -> CLEAR on START.
- IDLE: IN_READY=0. START -> CLEAR, and COUNT and ERR_FULL clear to 0.
- CLEAR: DEPTH consecutive cycles with WE=1, WADDR=0..DEPTH-1 and all W_* = 0. After row DEPTH-1 is written -> LOAD. BUSY=1. IN_READY=0.
- LOAD:
  - IN_READY=1 while COUNT<DEPTH.
  - A beat is accepted on a cycle with IN_VALID=1 and IN_READY=1.
  - On the next cycle: WE=1, WADDR=COUNT (pre-increment value), W_* = registered fields. COUNT increments. Write latency is 1 cycle.
  - WE=0 on cycles with no accepted beat.
  - Back-to-back beats are accepted every cycle, giving full throughput.
- Termination:
  - Accepted beat with IN_LAST=1 -> DONE after its write cycle. IN_READY drops the cycle after acceptance.
  - DEPTH-th beat accepted without IN_LAST -> DONE with ERR_FULL=1. IN_READY=0 from the cycle after acceptance, so no further beats are taken.
  - If the DEPTH-th beat also has IN_LAST=1, ERR_FULL stays 0.
- DONE: DONE=1, BUSY=0, IN_READY=0, WE=0. COUNT and ERR_FULL hold until the next START.
- START in CLEAR or LOAD is ignored. IN_VALID in IDLE, CLEAR or DONE is ignored, and the host must hold the beat.
- Rows not written during LOAD keep the zero value from CLEAR. The reader treats these as state 0 / failure 0.
- No field checks: values are written as given. IN_CUR is not used as the address; rows are sequential.

Optional Feature:
- Macro: TABLE_CSUM_EN.
- When defined:
  - Adds input CSUM_IN[SW-1:0] and output ERR_CSUM.
  - The writer keeps a running 8-bit XOR of IN_CUR ^ {4'b0,IN_CHARA} ^ IN_NEXT ^ IN_FAIL over every accepted beat. The running XOR clears on START.
  - On the IN_LAST beat, CSUM_IN is sampled. If the running XOR including that beat is not equal to CSUM_IN, ERR_CSUM=1 in DONE.
  - ERR_CSUM is sticky until START, and resets to 0.
- When undefined: no CSUM_IN or ERR_CSUM ports and no checksum logic.

Test Plan:
- Reset then START, no beats: WE high for 32 cycles, WADDR 0..31, data 0. Then IN_READY=1, BUSY=1, DONE=0.
- After CLEAR, 3 beats with IN_LAST on the 3rd, e.g. (0,C,1,0), (1,A,2,0), (2,3,3,5) -> writes at WADDR 0,1,2, each 1 cycle after acceptance. Then DONE=1, COUNT=3, ERR_FULL=0.
- IN_VALID toggled 1,0,1 with IN_READY held 1 -> WE pattern 0,1,0,1. No dropped or duplicated rows.
- 32 beats with no IN_LAST -> COUNT=32, ERR_FULL=1, DONE=1, IN_READY=0. A 33rd beat is held and never accepted.
- Assert RST low mid-LOAD after 2 beats -> all outputs 0 immediately. Then START gives a fresh CLEAR with COUNT=0.
- With TABLE_CSUM_EN: the 3-beat table above with CSUM_IN = correct XOR gives ERR_CSUM=0. With CSUM_IN = correct^0x01, ERR_CSUM=1 in DONE.

Source files
------------

// File: rtl/ac_table_writer.sv
// ac_table_writer: loader for the Aho-Corasick goto/failure tables.
// The host streams entries {cur, chara, next, fail} over valid/ready. The writer
// first clears every table row to zero, then writes the accepted entries to
// rows 0, 1, 2, ... one cycle after each is accepted. Loading ends on the
// IN_LAST beat, or after DEPTH beats (ERR_FULL is then set).
//
// Optional feature (macro TABLE_CSUM_EN): adds csum_in_i / err_csum_o. A running
// XOR of every accepted beat is compared with csum_in_i on the IN_LAST beat.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), async active-low reset
//   start_i              one-cycle pulse that begins clear + load (IDLE/DONE only)
//   in_valid_i/in_ready_o entry beat handshake
//   in_cur_i, in_chara_i, in_next_i, in_fail_i, in_last_i   entry fields
//   we_o, waddr_o, w_cur_o, w_chara_o, w_next_o, w_fail_o   table write port
//   busy_o, done_o       status: clearing/loading, table valid
//   count_o              entries written in the current load
//   err_full_o           DEPTH entries taken without IN_LAST
//   csum_in_i, err_csum_o  checksum compare (TABLE_CSUM_EN only)
module ac_table_writer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned SW    = 8,
  parameter int unsigned CW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [SW-1:0] in_cur_i,
  input  logic [CW-1:0] in_chara_i,
  input  logic [SW-1:0] in_next_i,
  input  logic [SW-1:0] in_fail_i,
  input  logic          in_last_i,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic [SW-1:0] w_cur_o,
  output logic [CW-1:0] w_chara_o,
  output logic [SW-1:0] w_next_o,
  output logic [SW-1:0] w_fail_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW:0]   count_o,
`ifdef TABLE_CSUM_EN
  input  logic [SW-1:0] csum_in_i,
  output logic          err_csum_o,
`endif
  output logic          err_full_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e        state_q;
  logic          in_ready_q;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [SW-1:0] w_cur_q;
  logic [CW-1:0] w_chara_q;
  logic [SW-1:0] w_next_q;
  logic [SW-1:0] w_fail_q;
  logic          busy_q;
  logic          done_q;
  logic [AW:0]   count_q;
  logic          err_full_q;
  // Terminating beat accepted; its write is on the bus this cycle.
  logic          fin_q;

  logic          accept_c;
  logic          last_row_c;

  assign accept_c   = in_valid_i & in_ready_q;
  assign last_row_c = (count_q == (AW+1)'(DEPTH - 1));

`ifdef TABLE_CSUM_EN
  logic [SW-1:0] csum_q;
  logic          err_csum_q;
  logic [SW-1:0] beat_xor_c;

  assign beat_xor_c = in_cur_i ^ SW'(in_chara_i) ^ in_next_i ^ in_fail_i;

  // Running XOR over accepted beats; compared against the host value on IN_LAST.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q     <= '0;
      err_csum_q <= 1'b0;
    end else if (start_i && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      csum_q     <= '0;
      err_csum_q <= 1'b0;
    end else if (state_q == ST_LOAD && accept_c) begin
      csum_q <= csum_q ^ beat_xor_c;
      if (in_last_i && ((csum_q ^ beat_xor_c) != csum_in_i)) begin
        err_csum_q <= 1'b1;
      end
    end
  end

  assign err_csum_o = err_csum_q;
`endif

  // Main FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      w_cur_q    <= '0;
      w_chara_q  <= '0;
      w_next_q   <= '0;
      w_fail_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      err_full_q <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          we_q       <= 1'b0;
          in_ready_q <= 1'b0;
          if (start_i) begin
            // First clear write (row 0) is issued on the cycle after START.
            state_q    <= ST_CLEAR;
            we_q       <= 1'b1;
            waddr_q    <= '0;
            w_cur_q    <= '0;
            w_chara_q  <= '0;
            w_next_q   <= '0;
            w_fail_q   <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            count_q    <= '0;
            err_full_q <= 1'b0;
            fin_q      <= 1'b0;
          end
        end

        ST_CLEAR: begin
          if (waddr_q == AW'(DEPTH - 1)) begin
            state_q    <= ST_LOAD;
            we_q       <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            waddr_q <= waddr_q + AW'(1);
          end
        end

        ST_LOAD: begin
          we_q <= 1'b0;
          if (fin_q) begin
            state_q <= ST_DONE;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (accept_c) begin
            we_q      <= 1'b1;
            waddr_q   <= count_q[AW-1:0];
            w_cur_q   <= in_cur_i;
            w_chara_q <= in_chara_i;
            w_next_q  <= in_next_i;
            w_fail_q  <= in_fail_i;
            count_q   <= count_q + (AW+1)'(1);
            if (in_last_i || last_row_c) begin
              in_ready_q <= 1'b0;
              fin_q      <= 1'b1;
              if (!in_last_i) begin
                err_full_q <= 1'b1;
              end
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o = in_ready_q;
  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign w_cur_o    = w_cur_q;
  assign w_chara_o  = w_chara_q;
  assign w_next_o   = w_next_q;
  assign w_fail_o   = w_fail_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign count_o    = count_q;
  assign err_full_o = err_full_q;

endmodule
